multicycle_control_unit: RTL and testbench

//  Multi-cycle RV32I control FSM; successor to the single-cycle decoder. Sequences fetch/decode/

---
 rtl/riscv_ctrl_pkg.sv | 39 +++
 rtl/multicycle_control_unit_alu_decoder.sv | 33 +++
 rtl/multicycle_control_unit.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I control unit: FSM states, opcodes, mux selects and ALU codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
      S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINKWB, S_LUI, S_AUIPC, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
   } alu_ctrl_t;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
   typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;
   typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_RS1, SRCA_ZERO} src_a_t;
   typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR} src_b_t;
   typedef enum logic [1:0] {RES_ALUOUT, RES_RDATA, RES_ALU} result_src_t;

   function automatic imm_src_t imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_JAL:           return IMM_J;
         OP_LUI, OP_AUIPC: return IMM_U;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU control decode from the FSM's ALUop and the instruction funct fields.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  alu_op_t     i_alu_op,
   input  logic [2:0]  i_funct3,
   input  logic        i_bit30,
   input  logic        i_op5,
   output alu_ctrl_t   o_alu_ctrl
);

   always_comb begin
      o_alu_ctrl = ALU_ADD;
      case (i_alu_op)
         ALUOP_SUB: o_alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               // bit 30 means SUB only for register ops; in OP-IMM it is an immediate bit
               3'b000:  o_alu_ctrl = (i_op5 && i_bit30) ? ALU_SUB : ALU_ADD;
               3'b001:  o_alu_ctrl = ALU_SLL;
               3'b010:  o_alu_ctrl = ALU_SLT;
               3'b011:  o_alu_ctrl = ALU_SLTU;
               3'b100:  o_alu_ctrl = ALU_XOR;
               3'b101:  o_alu_ctrl = i_bit30 ? ALU_SRA : ALU_SRL;
               3'b110:  o_alu_ctrl = ALU_OR;
               default: o_alu_ctrl = ALU_AND;
            endcase
         end
         default: o_alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM sequencing fetch/decode/execute/writeback over one memory port.
module multicycle_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ALU_CTRL_WIDTH = 4,
   parameter int IMM_SRC_WIDTH  = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_WIDTH-1:0]     instr,
   input  logic                      EQ,
   input  logic                      LT,
   input  logic                      LTU,
   input  logic                      mem_ready,
   output logic                      mem_req,
   output logic                      AdrSrc,
   output logic                      IRWrite,
   output logic                      PCWrite,
   output logic                      MemWrite,
   output logic                      RegWrite,
   output logic [1:0]                ResultSrc,
   output logic [1:0]                ALUsrcA,
   output logic [1:0]                ALUsrcB,
   output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
   output logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
   output logic                      illegal
);

   if (ALU_CTRL_WIDTH < 4 || IMM_SRC_WIDTH < 3) begin : g_bad_width
      $error("ALU_CTRL_WIDTH must be >= 4 and IMM_SRC_WIDTH >= 3");
   end

   state_t      r_state, w_next;
   logic        r_illegal;
   logic [6:0]  w_op;
   logic [2:0]  w_f3;
   logic        w_taken, w_br_bad;
   alu_op_t     w_alu_op;
   alu_ctrl_t   w_alu_ctrl;
   src_a_t      w_src_a;
   src_b_t      w_src_b;
   result_src_t w_res;
   logic        w_req, w_adr, w_irw, w_pcw, w_mw, w_rw;
   logic        w_unused;

   assign w_op     = instr[6:0];
   assign w_f3     = instr[14:12];
   assign w_unused = &{1'b0, instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

   always_comb begin
      w_taken  = 1'b0;
      w_br_bad = 1'b0;
      case (w_f3)
         3'b000:  w_taken = EQ;
         3'b001:  w_taken = !EQ;
         3'b100:  w_taken = LT;
         3'b101:  w_taken = !LT;
         3'b110:  w_taken = LTU;
         3'b111:  w_taken = !LTU;
         default: w_br_bad = 1'b1;
      endcase
   end

   alu_decoder u_alu_dec (
      .i_alu_op   (w_alu_op),
      .i_funct3   (w_f3),
      .i_bit30    (instr[30]),
      .i_op5      (w_op[5]),
      .o_alu_ctrl (w_alu_ctrl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_TRAP || (r_state == S_BRANCH && w_br_bad)) r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_alu_op = ALUOP_ADD;
      w_src_a  = SRCA_PC;
      w_src_b  = SRCB_RS2;
      w_res    = RES_ALUOUT;
      w_req    = 1'b0;
      w_adr    = 1'b0;
      w_irw    = 1'b0;
      w_pcw    = 1'b0;
      w_mw     = 1'b0;
      w_rw     = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_req   = 1'b1;
            w_src_b = SRCB_FOUR;
            w_res   = RES_ALU;
            w_irw   = mem_ready;
            w_pcw   = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            w_src_a = SRCA_OLDPC;
            w_src_b = SRCB_IMM;
            case (w_op)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_R:              w_next = S_EXECR;
               OP_I:              w_next = S_EXECI;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = S_JALR;
               OP_LUI:            w_next = S_LUI;
               OP_AUIPC:          w_next = S_AUIPC;
               default:           w_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            w_src_a = SRCA_RS1;
            w_src_b = SRCB_IMM;
            w_next  = (w_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_req = 1'b1;
            w_adr = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_res  = RES_RDATA;
            w_rw   = 1'b1;
            w_next = S_FETCH;
         end
         S_MEMWRITE: begin
            w_req = 1'b1;
            w_adr = 1'b1;
            w_mw  = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            w_alu_op = ALUOP_FUNCT;
            w_src_a  = SRCA_RS1;
            w_src_b  = (r_state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
            w_next   = S_ALUWB;
         end
         S_ALUWB: begin
            w_rw   = 1'b1;
            w_next = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_op = ALUOP_SUB;
            w_src_a  = SRCA_RS1;
            w_pcw    = w_taken;
            w_next   = S_FETCH;
         end
         S_JAL: begin
            w_src_a = SRCA_OLDPC;
            w_src_b = SRCB_FOUR;
            w_pcw   = 1'b1;
            w_next  = S_ALUWB;
         end
         S_JALR: begin
            w_src_a = SRCA_RS1;
            w_src_b = SRCB_IMM;
            w_res   = RES_ALU;
            w_pcw   = 1'b1;
            w_next  = S_LINKWB;
         end
         S_LINKWB: begin
            w_src_a = SRCA_OLDPC;
            w_src_b = SRCB_FOUR;
            w_res   = RES_ALU;
            w_rw    = 1'b1;
            w_next  = S_FETCH;
         end
         S_LUI, S_AUIPC: begin
            w_src_a = (r_state == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            w_src_b = SRCB_IMM;
            w_next  = S_ALUWB;
         end
         default: w_next = S_TRAP;
      endcase
   end

   // Reset gates every output combinationally so a mid-access abort is seen in the same cycle
   always_comb begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = '0;
      ALUsrcA   = '0;
      ALUsrcB   = '0;
      ImmSrc    = '0;
      ALUctrl   = '0;
      if (rst_n) begin
         mem_req   = w_req;
         AdrSrc    = w_adr;
         IRWrite   = w_irw;
         PCWrite   = w_pcw;
         MemWrite  = w_mw;
         RegWrite  = w_rw;
         ResultSrc = w_res;
         ALUsrcA   = w_src_a;
         ALUsrcB   = w_src_b;
         ImmSrc    = IMM_SRC_WIDTH'(imm_src_of(w_op));
         ALUctrl   = ALU_CTRL_WIDTH'(w_alu_ctrl);
      end
   end

   assign illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench: each cycle's hand-computed expected outputs are queued and checked by a monitor.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       mq, ad, ir, pc, mw, rw;
      logic [1:0] rs, a, b;
      logic [2:0] im;
      logic [3:0] al;
      logic       il;
   } exp_t;

   logic        clk, rst_n, EQ, LT, LTU, mem_ready;
   logic [31:0] instr, cur;
   logic        mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal;
   logic [1:0]  ResultSrc, ALUsrcA, ALUsrcB;
   logic [2:0]  ImmSrc;
   logic [3:0]  ALUctrl;

   exp_t  q[$];
   string nq[$];
   int    nvec = 0;
   int    nerr = 0;

   multicycle_control_unit #(.DATA_WIDTH(32), .ALU_CTRL_WIDTH(4), .IMM_SRC_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .LT(LT), .LTU(LTU),
      .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl),
      .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t ev(input logic mq, ad, ir, pc, mw, rw, input logic [1:0] rs, a, b,
                               input logic [2:0] im, input logic [3:0] al, input logic il);
      exp_t e;
      e = '{mq, ad, ir, pc, mw, rw, rs, a, b, im, al, il};
      return e;
   endfunction

   function automatic exp_t fe(input logic [2:0] im, input logic il);
      return ev(1, 0, 1, 1, 0, 0, 2, 0, 2, im, 0, il);
   endfunction
   function automatic exp_t de(input logic [2:0] im);
      return ev(0, 0, 0, 0, 0, 0, 0, 1, 1, im, 0, 0);
   endfunction
   function automatic exp_t wb(input logic [2:0] im);
      return ev(0, 0, 0, 0, 0, 1, 0, 0, 0, im, 0, 0);
   endfunction
   function automatic exp_t br(input logic pcw);
      return ev(0, 0, 0, pcw, 0, 0, 0, 2, 0, 2, 1, 0);
   endfunction

   // One clock of stimulus: drive inputs just after the edge and queue that cycle's expectation
   task automatic cyc(input logic rst, input logic rdy, input logic [2:0] flg, input exp_t e,
                      input string nm);
      @(posedge clk);
      #1;
      rst_n     = rst;
      mem_ready = rdy;
      {EQ, LT, LTU} = flg;
      instr     = cur;
      q.push_back(e);
      nq.push_back(nm);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t  e, act;
         string nm;
         e   = q.pop_front();
         nm  = nq.pop_front();
         act = '{mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc, ALUsrcA,
                 ALUsrcB, ImmSrc, ALUctrl, illegal};
         nvec++;
         if (act !== e) begin
            nerr++;
            $display("FAIL %s: got %h want %h (mq ad ir pc mw rw rs a b im al il)", nm, act, e);
         end
      end
   end

   initial begin
      rst_n = 1'b0; mem_ready = 1'b1; {EQ, LT, LTU} = 3'b000;
      cur = 32'h0000_0013; instr = cur;
      cyc(0, 1, 0, '0, "reset");

      cur = 32'h0020_81B3; // add
      cyc(1, 1, 0, fe(0, 0), "add fetch");
      cyc(1, 1, 0, de(0), "add decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,2,0, 0,0,0), "add execr");
      cyc(1, 1, 0, wb(0), "add aluwb");

      cur = 32'h4020_81B3; // sub
      cyc(1, 1, 0, fe(0, 0), "sub fetch");
      cyc(1, 1, 0, de(0), "sub decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,2,0, 0,1,0), "sub execr");
      cyc(1, 1, 0, wb(0), "sub aluwb");

      cur = 32'hFFF0_0093; // addi x1,x0,-1 : bit30 set but still ADD
      cyc(1, 1, 0, fe(0, 0), "addi fetch");
      cyc(1, 1, 0, de(0), "addi decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,2,1, 0,0,0), "addi execi");
      cyc(1, 1, 0, wb(0), "addi aluwb");

      cur = 32'h4031_5093; // srai
      cyc(1, 1, 0, fe(0, 0), "srai fetch");
      cyc(1, 1, 0, de(0), "srai decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,2,1, 0,9,0), "srai execi");
      cyc(1, 1, 0, wb(0), "srai aluwb");

      cur = 32'h0000_A283; // lw with fetch and read stalls
      cyc(1, 0, 0, ev(1,0,0,0,0,0, 2,0,2, 0,0,0), "lw fetch stall");
      cyc(1, 1, 0, fe(0, 0), "lw fetch");
      cyc(1, 1, 0, de(0), "lw decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,2,1, 0,0,0), "lw memadr");
      cyc(1, 0, 0, ev(1,1,0,0,0,0, 0,0,0, 0,0,0), "lw memread stall1");
      cyc(1, 0, 0, ev(1,1,0,0,0,0, 0,0,0, 0,0,0), "lw memread stall2");
      cyc(1, 1, 0, ev(1,1,0,0,0,0, 0,0,0, 0,0,0), "lw memread done");
      cyc(1, 1, 0, ev(0,0,0,0,0,1, 1,0,0, 0,0,0), "lw memwb");

      cur = 32'h0020_A223; // sw
      cyc(1, 1, 0, fe(1, 0), "sw fetch");
      cyc(1, 1, 0, de(1), "sw decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,2,1, 1,0,0), "sw memadr");
      cyc(1, 1, 0, ev(1,1,0,0,1,0, 0,0,0, 1,0,0), "sw memwrite");

      cur = 32'h0020_9463; // bne, EQ=0 -> taken
      cyc(1, 1, 0, fe(2, 0), "bne fetch");
      cyc(1, 1, 0, de(2), "bne decode");
      cyc(1, 1, 3'b000, br(1), "bne taken");
      cyc(1, 1, 0, fe(2, 0), "bne2 fetch");
      cyc(1, 1, 0, de(2), "bne2 decode");
      cyc(1, 1, 3'b100, br(0), "bne not taken");

      cur = 32'h0020_8463; // beq, EQ=1 -> taken
      cyc(1, 1, 0, fe(2, 0), "beq fetch");
      cyc(1, 1, 0, de(2), "beq decode");
      cyc(1, 1, 3'b100, br(1), "beq taken");

      cur = 32'h0020_E463; // bltu follows LTU only
      cyc(1, 1, 0, fe(2, 0), "bltu fetch");
      cyc(1, 1, 0, de(2), "bltu decode");
      cyc(1, 1, 3'b001, br(1), "bltu taken");
      cyc(1, 1, 0, fe(2, 0), "bltu2 fetch");
      cyc(1, 1, 0, de(2), "bltu2 decode");
      cyc(1, 1, 3'b110, br(0), "bltu not taken");

      cur = 32'h0020_D463; // bge, LT=0 -> taken
      cyc(1, 1, 0, fe(2, 0), "bge fetch");
      cyc(1, 1, 0, de(2), "bge decode");
      cyc(1, 1, 3'b001, br(1), "bge taken");

      cur = 32'h0080_00EF; // jal
      cyc(1, 1, 0, fe(3, 0), "jal fetch");
      cyc(1, 1, 0, de(3), "jal decode");
      cyc(1, 1, 0, ev(0,0,0,1,0,0, 0,1,2, 3,0,0), "jal pc");
      cyc(1, 1, 0, wb(3), "jal aluwb");

      cur = 32'h0001_00E7; // jalr
      cyc(1, 1, 0, fe(0, 0), "jalr fetch");
      cyc(1, 1, 0, de(0), "jalr decode");
      cyc(1, 1, 0, ev(0,0,0,1,0,0, 2,2,1, 0,0,0), "jalr pc");
      cyc(1, 1, 0, ev(0,0,0,0,0,1, 2,1,2, 0,0,0), "jalr linkwb");

      cur = 32'h1234_52B7; // lui
      cyc(1, 1, 0, fe(4, 0), "lui fetch");
      cyc(1, 1, 0, de(4), "lui decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,3,1, 4,0,0), "lui exec");
      cyc(1, 1, 0, wb(4), "lui aluwb");

      cur = 32'h0000_1297; // auipc
      cyc(1, 1, 0, fe(4, 0), "auipc fetch");
      cyc(1, 1, 0, de(4), "auipc decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,1,1, 4,0,0), "auipc exec");
      cyc(1, 1, 0, wb(4), "auipc aluwb");

      cur = 32'h0020_A463; // branch funct3 010: no write, sets illegal
      cyc(1, 1, 0, fe(2, 0), "badbr fetch");
      cyc(1, 1, 0, de(2), "badbr decode");
      cyc(1, 1, 3'b111, br(0), "badbr branch");
      cyc(1, 0, 0, ev(1,0,0,0,0,0, 2,0,2, 2,0,1), "badbr illegal set");
      cyc(0, 0, 0, '0, "badbr reset clears");

      cur = 32'h0020_A223; // sw aborted by reset in MEMWRITE
      cyc(1, 1, 0, fe(1, 0), "swrst fetch");
      cyc(1, 1, 0, de(1), "swrst decode");
      cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,2,1, 1,0,0), "swrst memadr");
      cyc(1, 0, 0, ev(1,1,0,0,1,0, 0,0,0, 1,0,0), "swrst memwrite");
      cyc(0, 0, 0, '0, "swrst reset drop");

      cur = 32'h0000_007F; // illegal opcode -> TRAP, sticky
      cyc(1, 1, 0, fe(0, 0), "trap fetch after release");
      cyc(1, 1, 0, de(0), "trap decode");
      cyc(1, 1, 0, '0, "trap entry");
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, ev(0,0,0,0,0,0, 0,0,0, 0,0,1), "trap hold");
      cyc(0, 1, 0, '0, "trap reset clears");
      cyc(1, 0, 0, ev(1,0,0,0,0,0, 2,0,2, 0,0,0), "post-trap fetch");

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         nerr++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
